// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions for the transmit framer and the matching receive checker.
// Both ends call crc8_step so the bit-serial update has a single definition.
package crc8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_WAIT = 3'd2,
    ST_CRC  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    LFSR_HOLD  = 2'd0,
    LFSR_INIT  = 2'd1,
    LFSR_STEP  = 2'd2,
    LFSR_SHIFT = 2'd3
  } lfsr_op_t;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din,
                                           input logic [7:0] poly);
    logic fb;
    fb = din ^ crc[7];
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_bit_lfsr.sv
// 8-bit CRC register: hold, reload INIT, absorb one message bit, or shift the
// finished CRC out MSB-first (zero fill).
module crc8_bit_lfsr
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT,
  parameter logic [7:0] INIT = CRC8_INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  lfsr_op_t   i_op,
  input  logic       i_bit,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_crc <= INIT;
    end else begin
      case (i_op)
        LFSR_INIT:  r_crc <= INIT;
        LFSR_STEP:  r_crc <= crc8_step(r_crc, i_bit, POLY);
        LFSR_SHIFT: r_crc <= {r_crc[6:0], 1'b0};
        default:    r_crc <= r_crc;
      endcase
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/crc8_tx_framer.sv
// Bit-serial CRC-8 frame transmitter: bytes in over valid/ready, bits out MSB-first,
// CRC appended MSB-first, then a forced idle gap so the receiver can evaluate.
module crc8_tx_framer
  import crc8_pkg::*;
#(
  parameter logic [7:0]  POLY       = CRC8_POLY_DEFAULT,
  parameter logic [7:0]  INIT       = CRC8_INIT_DEFAULT,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic       tx_bit,
  output logic       tx_is_crc,
  output logic       tx_last,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_shreg, w_shreg_nxt;
  logic       r_last_f, w_last_f_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_gap, w_gap_nxt;
  logic       r_frame_done, w_frame_done_nxt;
  logic       r_underrun, w_underrun_nxt;
  lfsr_op_t   w_lfsr_op;
  logic [7:0] w_crc;
  logic       w_consume, w_boundary, w_accept;

  crc8_bit_lfsr #(.POLY(POLY), .INIT(INIT)) u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .i_op   (w_lfsr_op),
    .i_bit  (r_shreg[7]),
    .o_crc  (w_crc)
  );

  // Serial outputs are pure decodes of registered state, so they hold while stalled.
  assign tx_valid   = (r_state == ST_DATA) || (r_state == ST_CRC);
  assign tx_is_crc  = (r_state == ST_CRC);
  assign tx_bit     = (r_state == ST_DATA) ? r_shreg[7] :
                      (r_state == ST_CRC)  ? w_crc[7]   : 1'b0;
  assign tx_last    = (r_state == ST_CRC) && (r_cnt == 3'd0);
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;

  assign w_consume  = tx_valid && tx_ready;
  assign w_boundary = (r_state == ST_DATA) && (r_cnt == 3'd0) && tx_ready && !r_last_f;
  assign s_ready    = (r_state == ST_IDLE) || (r_state == ST_WAIT) || w_boundary;
  assign w_accept   = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_last_f     <= 1'b0;
      r_cnt        <= '0;
      r_gap        <= '0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_last_f     <= w_last_f_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gap        <= w_gap_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_underrun   <= w_underrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_last_f_nxt     = r_last_f;
    w_cnt_nxt        = r_cnt;
    w_gap_nxt        = r_gap;
    w_lfsr_op        = LFSR_HOLD;
    w_frame_done_nxt = 1'b0;
    w_underrun_nxt   = 1'b0;
    case (r_state)
      ST_IDLE, ST_WAIT: begin
        if (w_accept) begin
          w_shreg_nxt  = s_data;
          w_last_f_nxt = s_last;
          w_cnt_nxt    = 3'd7;
          w_state_nxt  = ST_DATA;
          // WAIT keeps the running CRC; only a fresh frame reloads INIT.
          if (r_state == ST_IDLE) w_lfsr_op = LFSR_INIT;
        end
      end
      ST_DATA: begin
        if (w_consume) begin
          w_lfsr_op   = LFSR_STEP;
          w_shreg_nxt = {r_shreg[6:0], 1'b0};
          w_cnt_nxt   = r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            if (r_last_f) begin
              w_state_nxt = ST_CRC;
              w_cnt_nxt   = 3'd7;
            end else if (w_accept) begin
              w_shreg_nxt  = s_data;
              w_last_f_nxt = s_last;
              w_cnt_nxt    = 3'd7;
            end else begin
              w_state_nxt    = ST_WAIT;
              w_underrun_nxt = 1'b1;
            end
          end
        end
      end
      ST_CRC: begin
        if (w_consume) begin
          w_lfsr_op = LFSR_SHIFT;
          w_cnt_nxt = r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            w_state_nxt      = ST_GAP;
            w_gap_nxt        = GAP_LOAD;
            w_frame_done_nxt = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (r_gap == 4'd0) w_state_nxt = ST_IDLE;
        else               w_gap_nxt   = r_gap - 4'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_crc8_tx_framer.sv
// Self-checking bench for crc8_tx_framer against a polynomial long-division reference.
module tb_crc8_tx_framer;

  localparam int GAP = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic       tx_ready = 1'b0;
  logic       tx_valid, tx_bit, tx_is_crc, tx_last, frame_done, underrun;

  always #5 clk = ~clk;

  crc8_tx_framer #(.POLY(8'h07), .INIT(8'h00), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_bit(tx_bit),
    .tx_is_crc(tx_is_crc), .tx_last(tx_last), .frame_done(frame_done), .underrun(underrun)
  );

  int passed = 0;
  int total  = 0;

  logic [7:0] frm[$];
  bit obs_bits[$];
  bit obs_crc[$];
  bit obs_last[$];
  int obs_underruns, obs_vlow, obs_gap, obs_unstable, obs_done_count;
  bit obs_done_ok, obs_timeout;

  // Remainder of M(x)*x^8 divided by x^8+x^2+x+1 (INIT is zero).
  function automatic logic [7:0] model_crc(input logic [7:0] b[$]);
    logic [8:0] rem = '0;
    foreach (b[k]) for (int i = 7; i >= 0; i--) begin
      rem = {rem[7:0], b[k][i]};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    for (int i = 0; i < 8; i++) begin
      rem = {rem[7:0], 1'b0};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  // Receiver view: a clean frame (data followed by its CRC) divides evenly.
  function automatic logic [7:0] rx_remainder(input bit q[$]);
    logic [8:0] rem = '0;
    foreach (q[k]) begin
      rem = {rem[7:0], q[k]};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  task automatic build_exp(input logic [7:0] b[$], output bit e[$]);
    logic [7:0] c;
    e.delete();
    foreach (b[k]) for (int i = 7; i >= 0; i--) e.push_back(b[k][i]);
    c = model_crc(b);
    for (int i = 7; i >= 0; i--) e.push_back(c[i]);
  endtask

  function automatic int count_diff(input bit a[$], input bit e[$]);
    int n = 0;
    if (a.size() != e.size()) return 1000 + a.size();
    foreach (a[k]) if (a[k] != e[k]) n++;
    return n;
  endfunction

  function automatic logic [7:0] tail_crc();
    logic [7:0] c = '0;
    if (obs_bits.size() >= 8)
      for (int i = 0; i < 8; i++) c[7-i] = obs_bits[obs_bits.size() - 8 + i];
    return c;
  endfunction

  // Drives one frame and records what the DUT emits; withholds byte hold_idx so
  // that tx_valid stays low for hold_cycles cycles.
  task automatic run_frame(input logic [7:0] b[$], input int stall_pct,
                           input int hold_idx, input int hold_cycles);
    int bi = 0, wcnt = 0, cyc = 0, phase = 0;
    bit fin = 0, started = 0, prev_stall = 0, hold;
    logic pv = 0, pb = 0, pc = 0, pl = 0;
    obs_bits.delete(); obs_crc.delete(); obs_last.delete();
    obs_underruns = 0; obs_vlow = 0; obs_gap = 0; obs_unstable = 0; obs_done_count = 0;
    obs_done_ok = 0; obs_timeout = 0;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall && (tx_valid !== pv || tx_bit !== pb || tx_is_crc !== pc || tx_last !== pl))
        obs_unstable++;
      tx_ready = ($urandom_range(0, 99) >= stall_pct);
      hold     = (bi == hold_idx) && (wcnt < hold_cycles - 1);
      s_valid  = (bi < b.size()) && !hold;
      s_data   = (bi < b.size()) ? b[bi] : 8'($urandom);
      s_last   = (bi == b.size() - 1);
      #1;
      if (underrun === 1'b1) obs_underruns++;
      if (frame_done === 1'b1) obs_done_count++;
      if (phase == 2) begin
        if (s_ready === 1'b1) fin = 1;
        else obs_gap++;
      end
      if (phase == 1) begin
        phase = 2;
        if (frame_done === 1'b1 && tx_valid === 1'b0 && s_ready === 1'b0) obs_done_ok = 1;
        obs_gap++;
      end
      if (phase == 0 && started && tx_valid === 1'b0) obs_vlow++;
      if (tx_valid === 1'b1) started = 1;
      if (hold && tx_valid === 1'b0) wcnt++;
      if (tx_valid === 1'b1 && tx_ready) begin
        obs_bits.push_back(tx_bit);
        obs_crc.push_back(tx_is_crc);
        obs_last.push_back(tx_last);
        if (tx_last === 1'b1 && phase == 0) phase = 1;
      end
      if (s_valid && s_ready === 1'b1) bi++;
      prev_stall = (tx_valid === 1'b1) && !tx_ready;
      pv = tx_valid; pb = tx_bit; pc = tx_is_crc; pl = tx_last;
    end
    if (!fin) obs_timeout = 1;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b1; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", tx_valid); else passed++;
    total++; if (tx_bit !== 1'b0) $display("FAIL reset_tx_bit got %b want 0", tx_bit); else passed++;
    total++; if (tx_is_crc !== 1'b0) $display("FAIL reset_tx_is_crc got %b want 0", tx_is_crc); else passed++;
    total++; if (tx_last !== 1'b0) $display("FAIL reset_tx_last got %b want 0", tx_last); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL reset_underrun got %b want 0", underrun); else passed++;
    total++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got %b want 1", s_ready); else passed++;
    s_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    bit e[$];
    int nc = 0, nl = 0;
    frm.delete(); frm.push_back(8'h01);
    run_frame(frm, 0, -1, 0);
    build_exp(frm, e);
    foreach (obs_crc[k]) if (obs_crc[k] != (k >= 8)) nc++;
    foreach (obs_last[k]) if (obs_last[k] != (k == 15)) nl++;
    total++; if (obs_timeout !== 1'b0) $display("FAIL single_timeout got %b want 0", obs_timeout); else passed++;
    total++; if (count_diff(obs_bits, e) != 0) $display("FAIL single_bits diff %0d want 0", count_diff(obs_bits, e)); else passed++;
    total++; if (tail_crc() !== 8'h07) $display("FAIL single_crc got %h want 07", tail_crc()); else passed++;
    total++; if (obs_bits.size() != 16 || nc != 0) $display("FAIL single_is_crc bad %0d size %0d want 0/16", nc, obs_bits.size()); else passed++;
    total++; if (nl != 0) $display("FAIL single_tx_last bad %0d want 0", nl); else passed++;
    total++; if (obs_gap != GAP) $display("FAIL single_gap got %0d want %0d", obs_gap, GAP); else passed++;
    total++; if (obs_done_ok !== 1'b1 || obs_done_count != 1) $display("FAIL single_frame_done ok %b count %0d want 1/1", obs_done_ok, obs_done_count); else passed++;
    total++; if (obs_underruns != 0) $display("FAIL single_underrun got %0d want 0", obs_underruns); else passed++;
  endtask

  task automatic test_check_string();
    bit e[$];
    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(8'(8'h31 + i));
    run_frame(frm, 0, -1, 0);
    build_exp(frm, e);
    total++; if (tail_crc() !== 8'hF4) $display("FAIL check_crc got %h want f4", tail_crc()); else passed++;
    total++; if (count_diff(obs_bits, e) != 0) $display("FAIL check_bits diff %0d want 0", count_diff(obs_bits, e)); else passed++;
    total++; if (rx_remainder(obs_bits) !== 8'h00) $display("FAIL check_loopback rem %h want 00", rx_remainder(obs_bits)); else passed++;
    total++; if (obs_vlow != 0) $display("FAIL check_bubbles got %0d want 0", obs_vlow); else passed++;
  endtask

  task automatic test_zeros_corrupt();
    bit q[$];
    int idx;
    frm.delete(); frm.push_back(8'h00); frm.push_back(8'h00);
    run_frame(frm, 0, -1, 0);
    total++; if (tail_crc() !== 8'h00 || obs_bits.size() != 24) $display("FAIL zeros_crc got %h size %0d want 00/24", tail_crc(), obs_bits.size()); else passed++;
    q = obs_bits;
    idx = $urandom_range(0, 15);
    if (q.size() > idx) q[idx] = ~q[idx];
    total++; if (rx_remainder(q) === 8'h00) $display("FAIL zeros_corrupt rem %h want nonzero", rx_remainder(q)); else passed++;
  endtask

  task automatic test_stall();
    bit e[$], q0[$];
    frm.delete();
    for (int i = 0; i < 4; i++) frm.push_back(8'($urandom));
    run_frame(frm, 0, -1, 0);
    q0 = obs_bits;
    run_frame(frm, 30, -1, 0);
    build_exp(frm, e);
    total++; if (count_diff(obs_bits, q0) != 0) $display("FAIL stall_vs_unstalled diff %0d want 0", count_diff(obs_bits, q0)); else passed++;
    total++; if (count_diff(obs_bits, e) != 0) $display("FAIL stall_vs_model diff %0d want 0", count_diff(obs_bits, e)); else passed++;
    total++; if (obs_unstable != 0) $display("FAIL stall_stability got %0d want 0", obs_unstable); else passed++;
    total++; if (obs_timeout !== 1'b0 || obs_done_ok !== 1'b1) $display("FAIL stall_completion timeout %b done %b want 0/1", obs_timeout, obs_done_ok); else passed++;
  endtask

  task automatic test_underrun();
    logic [7:0] c0;
    bit e[$];
    frm.delete(); frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
    run_frame(frm, 0, -1, 0);
    c0 = tail_crc();
    run_frame(frm, 0, 1, 5);
    build_exp(frm, e);
    total++; if (obs_underruns != 1) $display("FAIL underrun_pulse got %0d want 1", obs_underruns); else passed++;
    total++; if (obs_vlow != 5) $display("FAIL underrun_idle got %0d want 5", obs_vlow); else passed++;
    total++; if (tail_crc() !== c0) $display("FAIL underrun_crc_vs_nogap got %h want %h", tail_crc(), c0); else passed++;
    total++; if (count_diff(obs_bits, e) != 0) $display("FAIL underrun_bits diff %0d want 0", count_diff(obs_bits, e)); else passed++;
  endtask

  task automatic test_reset_mid_crc();
    int n = 0;
    s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    while (tx_is_crc !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    total++; if (tx_is_crc !== 1'b1 || tx_last !== 1'b0) $display("FAIL midcrc_reached is_crc %b last %b want 1/0", tx_is_crc, tx_last); else passed++;
    reset_n = 1'b0;
    @(negedge clk);
    total++; if ({tx_valid, tx_bit, tx_is_crc, tx_last, frame_done, underrun} !== 6'b0)
      $display("FAIL midcrc_outputs got %b want 000000", {tx_valid, tx_bit, tx_is_crc, tx_last, frame_done, underrun}); else passed++;
    total++; if (s_ready !== 1'b1) $display("FAIL midcrc_s_ready got %b want 1", s_ready); else passed++;
    reset_n = 1'b1;
    frm.delete(); frm.push_back(8'h01);
    run_frame(frm, 0, -1, 0);
    total++; if (tail_crc() !== 8'h07 || obs_bits.size() != 16) $display("FAIL midcrc_next_crc got %h size %0d want 07/16", tail_crc(), obs_bits.size()); else passed++;
  endtask

  task automatic test_back_to_back();
    bit e[$];
    int len;
    for (int f = 0; f < 4; f++) begin
      frm.delete();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
      run_frame(frm, 30, -1, 0);
      build_exp(frm, e);
      total++; if (count_diff(obs_bits, e) != 0) $display("FAIL b2b_bits frame %0d diff %0d want 0", f, count_diff(obs_bits, e)); else passed++;
      total++; if (obs_done_ok !== 1'b1 || obs_gap != GAP || obs_vlow != 0)
        $display("FAIL b2b_framing frame %0d done %b gap %0d idle %0d want 1/%0d/0", f, obs_done_ok, obs_gap, obs_vlow, GAP); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_check_string();
    test_zeros_corrupt();
    test_stall();
    test_underrun();
    test_reset_mid_crc();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
